// File: rtl/pb_serial_addsub.sv
// Push-button driven bit-serial add/subtract unit with operand registers
// and an accumulate mode. One result bit is produced per clock, LSB first.
module pb_serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pb1,
   input  logic             pb2,
   input  logic             pb3,
   input  logic             pb4,
   input  logic             pb5,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [5:1]       pb, prev, rise;
   logic             accept, ld_a, ld_b, start, start_sub, start_acc, last;
   logic [WIDTH-1:0] a, b, bp, res, result_nxt;
   logic             c, acc_op, bit_s, carry_nxt;
   logic [IW-1:0]    idx;

   assign pb   = {pb5, pb4, pb3, pb2, pb1};
   assign rise = pb & ~prev;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Full adder for the current bit, plus the fully assembled result word
   assign bit_s      = a[idx] ^ bp[idx] ^ c;
   assign carry_nxt  = (a[idx] & bp[idx]) | (a[idx] & c) | (bp[idx] & c);
   assign result_nxt = {bit_s, res[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Button history; resets high so a button held through reset is not a press
   always_ff @(posedge clk) begin
      if (rst) prev <= '1;
      else     prev <= pb;
   end

   // Command decode and next state: loads beat ops, and pb4 > pb3 > pb5
   always_comb begin
      state_nxt = state;
      accept    = (state != RUN);
      ld_a      = accept & rise[1];
      ld_b      = accept & rise[2];
      start     = accept & ~(rise[1] | rise[2]) & (|rise[5:3]);
      start_sub = start & rise[4];
      start_acc = start & ~rise[4] & ~rise[3] & rise[5];
      last      = (state == RUN) && (idx == LAST);
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand registers, serial datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a      <= '0;
         b      <= '0;
         bp     <= '0;
         res    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         c      <= 1'b0;
         acc_op <= 1'b0;
         idx    <= '0;
      end else begin
         if (ld_a) a <= y;
         if (ld_b) b <= y;
         if (start) begin
            bp     <= start_sub ? ~b : b;
            c      <= start_sub;
            idx    <= '0;
            acc_op <= start_acc;
         end else if (state == RUN) begin
            res <= result_nxt;
            c   <= carry_nxt;
            idx <= idx + 1'b1;
            // sum/cout only change once the whole word is assembled
            if (last) begin
               sum  <= result_nxt;
               cout <= carry_nxt;
               if (acc_op) a <= result_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_pb_serial_addsub.sv
// Self-checking bench: a 4-bit and an 8-bit instance driven by the same
// buttons, each checked against an arithmetic reference model.
module tb_pb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:1] pbv;
   logic [3:0] y4, sum4;
   logic [7:0] y8, sum8;
   logic       cout4, busy4, done4, cout8, busy8, done8;

   int checks = 0;
   int errors = 0;
   int busy4_cnt = 0, done4_cnt = 0, busy8_cnt = 0, done8_cnt = 0;

   // reference model state
   int unsigned ma4, mb4, ms4, mc4, ma8, mb8, ms8, mc8;

   always #5 clk = ~clk;

   pb_serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .pb1(pbv[1]), .pb2(pbv[2]), .pb3(pbv[3]),
      .pb4(pbv[4]), .pb5(pbv[5]), .y(y4), .sum(sum4), .cout(cout4),
      .busy(busy4), .done(done4)
   );

   pb_serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .pb1(pbv[1]), .pb2(pbv[2]), .pb3(pbv[3]),
      .pb4(pbv[4]), .pb5(pbv[5]), .y(y8), .sum(sum8), .cout(cout8),
      .busy(busy8), .done(done8)
   );

   // cycle counters for busy and done
   always @(posedge clk) begin
      if (busy4) busy4_cnt <= busy4_cnt + 1;
      if (done4) done4_cnt <= done4_cnt + 1;
      if (busy8) busy8_cnt <= busy8_cnt + 1;
      if (done8) done8_cnt <= done8_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_calc(input int op, input int unsigned a, input int unsigned b,
                                    input int w, output int unsigned s, output int unsigned c);
      int unsigned mask, t;
      mask = (32'd1 << w) - 1;
      if (op == 4) t = a + ((~b) & mask) + 1;
      else         t = a + b;
      s = t & mask;
      c = (t >> w) & 1;
   endfunction

   function automatic int eff_op(input logic [5:1] btn);
      if (btn[4]) return 4;
      if (btn[3]) return 3;
      return 5;
   endfunction

   task automatic load(input int n, input logic [3:0] v4, input logic [7:0] v8);
      y4 = v4; y8 = v8;
      pbv[n] = 1'b1;
      @(negedge clk);
      pbv[n] = 1'b0;
      @(negedge clk);
      if (n == 1) begin ma4 = v4; ma8 = v8; end
      else        begin mb4 = v4; mb8 = v8; end
   endtask

   task automatic do_op(input string tag, input logic [5:1] btn, input int hold, input bit poke);
      int b4, d4, b8, d8, op;
      int unsigned s4, c4, s8, c8;
      b4 = busy4_cnt; d4 = done4_cnt; b8 = busy8_cnt; d8 = done8_cnt;
      op = eff_op(btn);
      ref_calc(op, ma4, mb4, 4, s4, c4);
      ref_calc(op, ma8, mb8, 8, s8, c8);
      pbv = btn;
      @(negedge clk);
      chk({tag, "_busy_now4"}, 32'(busy4), 1);
      chk({tag, "_stable4"}, 32'(sum4), ms4);
      chk({tag, "_stable8"}, 32'(sum8), ms8);
      if (poke) pbv[4] = 1'b1;
      repeat (hold) @(negedge clk);
      pbv = '0;
      repeat (11) @(negedge clk);
      ms4 = s4; mc4 = c4; ms8 = s8; mc8 = c8;
      if (op == 5) begin ma4 = s4; ma8 = s8; end
      chk({tag, "_sum4"}, 32'(sum4), ms4);
      chk({tag, "_cout4"}, 32'(cout4), mc4);
      chk({tag, "_sum8"}, 32'(sum8), ms8);
      chk({tag, "_cout8"}, 32'(cout8), mc8);
      chk({tag, "_busycyc4"}, 32'(busy4_cnt - b4), 4);
      chk({tag, "_busycyc8"}, 32'(busy8_cnt - b8), 8);
      chk({tag, "_done4"}, 32'(done4_cnt - d4), 1);
      chk({tag, "_done8"}, 32'(done8_cnt - d8), 1);
   endtask

   initial begin
      int b4, d4;
      logic [5:1] v;
      pbv = '1; rst = 1'b1; y4 = '0; y8 = '0;
      ma4 = 0; mb4 = 0; ms4 = 0; mc4 = 0; ma8 = 0; mb8 = 0; ms8 = 0; mc8 = 0;
      repeat (3) @(negedge clk);
      chk("rst_sum4", 32'(sum4), 0);
      chk("rst_cout4", 32'(cout4), 0);
      chk("rst_busy4", 32'(busy4), 0);
      chk("rst_done4", 32'(done4), 0);
      chk("rst_sum8", 32'(sum8), 0);
      chk("rst_busy8", 32'(busy8), 0);

      // buttons held across reset release must not issue commands
      rst = 1'b0;
      b4 = busy4_cnt; d4 = done4_cnt;
      repeat (4) @(negedge clk);
      chk("held_busy", 32'(busy4_cnt - b4), 0);
      chk("held_done", 32'(done4_cnt - d4), 0);
      pbv = '0;
      @(negedge clk);

      // add with carry out; 8-bit instance gets 0xFF + 0x01
      load(1, 4'b1111, 8'hFF);
      load(2, 4'b0001, 8'h01);
      do_op("add", 5'b00100, 1, 0);
      chk("add_sum_lit", 32'(sum4), 0);
      chk("add_cout_lit", 32'(cout4), 1);
      chk("par_sum_lit", 32'(sum8), 0);
      chk("par_cout_lit", 32'(cout8), 1);

      // subtract with and without borrow
      load(1, 4'b1000, 8'($urandom));
      load(2, 4'b1001, 8'($urandom));
      do_op("sub_borrow", 5'b01000, 1, 0);
      chk("sub_borrow_lit", {27'd0, cout4, sum4}, {27'd0, 1'b0, 4'b1111});
      load(1, 4'b1001, 8'($urandom));
      load(2, 4'b1000, 8'($urandom));
      do_op("sub_noborrow", 5'b01000, 1, 0);
      chk("sub_noborrow_lit", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'b0001});

      // accumulate twice, then A-B exposes final A
      load(1, 4'b0011, 8'($urandom));
      load(2, 4'b0010, 8'($urandom));
      do_op("acc1", 5'b10000, 1, 0);
      chk("acc1_lit", 32'(sum4), 5);
      do_op("acc2", 5'b10000, 1, 0);
      chk("acc2_lit", 32'(sum4), 7);
      do_op("acc_check", 5'b01000, 1, 0);
      chk("acc_final_a_lit", 32'(sum4), 5);

      // held button: exactly one operation
      do_op("hold20", 5'b00100, 20, 0);
      // pb4 pressed while busy is ignored
      do_op("poke", 5'b00100, 1, 1);
      // pb3 and pb4 together: subtract wins
      do_op("both34", 5'b01100, 1, 0);

      // load and op edge in the same cycle: load only
      b4 = busy4_cnt; d4 = done4_cnt;
      y4 = 4'($urandom); y8 = 8'($urandom);
      pbv = 5'b00101;
      @(negedge clk);
      pbv = '0;
      repeat (11) @(negedge clk);
      ma4 = y4; ma8 = y8;
      chk("ldop_busy", 32'(busy4_cnt - b4), 0);
      chk("ldop_done", 32'(done4_cnt - d4), 0);
      do_op("ldop_after", 5'b00100, 1, 0);

      // reset two cycles into RUN
      d4 = done4_cnt;
      pbv = 5'b00100;
      @(negedge clk);
      pbv = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rrun_busy4", 32'(busy4), 0);
      chk("rrun_sum4", 32'(sum4), 0);
      chk("rrun_cout4", 32'(cout4), 0);
      chk("rrun_busy8", 32'(busy8), 0);
      chk("rrun_sum8", 32'(sum8), 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("rrun_nodone", 32'(done4_cnt - d4), 0);
      ma4 = 0; mb4 = 0; ms4 = 0; mc4 = 0; ma8 = 0; mb8 = 0; ms8 = 0; mc8 = 0;
      do_op("after_rst", 5'b01000, 1, 0);

      // randomized operations
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) load(1, 4'($urandom), 8'($urandom));
         if ($urandom_range(0, 1) == 1) load(2, 4'($urandom), 8'($urandom));
         v = '0;
         v[$urandom_range(3, 5)] = 1'b1;
         do_op("rand", v, 1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
